// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the two-road phase scheduler.
package traffic_pkg;

  typedef enum logic [2:0] {
    CLR_A = 3'd0,
    GRN_A = 3'd1,
    YEL_A = 3'd2,
    CLR_B = 3'd3,
    GRN_B = 3'd4,
    YEL_B = 3'd5
  } phase_t;

  // Per-road lamp triple, ordered {red, yellow, green}
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Returns {ra, ya, ga, rb, yb, gb} for a phase
  function automatic logic [5:0] lamps_of(input phase_t p);
    logic [5:0] v;
    case (p)
      GRN_A:   v = {LAMP_G, LAMP_R};
      YEL_A:   v = {LAMP_Y, LAMP_R};
      GRN_B:   v = {LAMP_R, LAMP_G};
      YEL_B:   v = {LAMP_R, LAMP_Y};
      default: v = {LAMP_R, LAMP_R};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/traffic_phase_sched_phase_timer.sv
// Per-phase cycle timer: clears on phase change, saturates at MAX_GREEN-1.
module phase_timer #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YEL_CYC   = 2,
  parameter int CLR_CYC   = 1,
  parameter int TW        = $clog2(MAX_GREEN + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  output logic [TW-1:0] tmr,
  output logic [TW-1:0] tmr_nx,
  output logic          clr_done,
  output logic          yel_done,
  output logic          min_rch,
  output logic          max_rch
);

  localparam logic [TW-1:0] T_MAX = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] T_MIN = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] T_YEL = TW'(YEL_CYC - 1);
  localparam logic [TW-1:0] T_CLR = TW'(CLR_CYC - 1);

  always_comb begin
    tmr_nx = tmr;
    if (clr)
      tmr_nx = '0;
    else if (tmr != T_MAX)
      tmr_nx = tmr + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmr <= '0;
    else
      tmr <= tmr_nx;
  end

  assign clr_done = (tmr == T_CLR);
  assign yel_done = (tmr == T_YEL);
  assign min_rch  = (tmr >= T_MIN);
  assign max_rch  = (tmr == T_MAX);

endmodule

// File: rtl/traffic_phase_sched.sv
// Demand-driven two-road phase scheduler with min/max green, yellow, all-red and walk.
module traffic_phase_sched
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 10,
  parameter int YEL_CYC   = 2,
  parameter int CLR_CYC   = 1,
  parameter int WALK_CYC  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sa,
  input  logic       sb,
  input  logic       ped_a,
  input  logic       ped_b,
  output logic       ra,
  output logic       ya,
  output logic       ga,
  output logic       rb,
  output logic       yb,
  output logic       gb,
  output logic       walk_a,
  output logic       walk_b,
  output logic [2:0] phase
);

  localparam int TW = $clog2(MAX_GREEN + 1);
  localparam logic [TW-1:0] T_WALK = TW'(WALK_CYC);

  phase_t        state_q, state_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic          clr_done, yel_done, min_rch, max_rch;
  logic          lat_a, lat_b, arm_a, arm_b;
  logic          lat_a_nx, lat_b_nx, arm_a_nx, arm_b_nx;
  logic          walk_a_nx, walk_b_nx;
  logic          a_dem, b_dem, chg, enter_ga, enter_gb;

  phase_timer #(
    .MIN_GREEN (MIN_GREEN),
    .MAX_GREEN (MAX_GREEN),
    .YEL_CYC   (YEL_CYC),
    .CLR_CYC   (CLR_CYC),
    .TW        (TW)
  ) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (chg),
    .tmr      (tmr),
    .tmr_nx   (tmr_nx),
    .clr_done (clr_done),
    .yel_done (yel_done),
    .min_rch  (min_rch),
    .max_rch  (max_rch)
  );

  assign a_dem = sa | lat_a;
  assign b_dem = sb | lat_b;

  always_comb begin
    state_nx = state_q;
    case (state_q)
      CLR_A: if (clr_done) state_nx = GRN_A;
      GRN_A: if (min_rch && b_dem && (!a_dem || max_rch)) state_nx = YEL_A;
      YEL_A: if (yel_done) state_nx = CLR_B;
      CLR_B: if (clr_done) state_nx = GRN_B;
      GRN_B: if (min_rch && a_dem && (!b_dem || max_rch)) state_nx = YEL_B;
      YEL_B: if (yel_done) state_nx = CLR_A;
      default: state_nx = CLR_A;
    endcase
  end

  assign chg      = (state_nx != state_q);
  assign enter_ga = chg && (state_nx == GRN_A);
  assign enter_gb = chg && (state_nx == GRN_B);

  // A request pending at green entry is consumed into arm_x; one arriving on
  // that same cycle is kept for the next service.
  always_comb begin
    lat_a_nx  = enter_ga ? ped_a : (lat_a | ped_a);
    lat_b_nx  = enter_gb ? ped_b : (lat_b | ped_b);
    arm_a_nx  = (state_nx == GRN_A) ? (enter_ga ? lat_a : arm_a) : 1'b0;
    arm_b_nx  = (state_nx == GRN_B) ? (enter_gb ? lat_b : arm_b) : 1'b0;
    walk_a_nx = (state_nx == GRN_A) && arm_a_nx && (tmr_nx < T_WALK);
    walk_b_nx = (state_nx == GRN_B) && arm_b_nx && (tmr_nx < T_WALK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q                  <= CLR_A;
      lat_a                    <= 1'b0;
      lat_b                    <= 1'b0;
      arm_a                    <= 1'b0;
      arm_b                    <= 1'b0;
      {ra, ya, ga, rb, yb, gb} <= {LAMP_R, LAMP_R};
      walk_a                   <= 1'b0;
      walk_b                   <= 1'b0;
    end else begin
      state_q                  <= state_nx;
      lat_a                    <= lat_a_nx;
      lat_b                    <= lat_b_nx;
      arm_a                    <= arm_a_nx;
      arm_b                    <= arm_b_nx;
      {ra, ya, ga, rb, yb, gb} <= lamps_of(state_nx);
      walk_a                   <= walk_a_nx;
      walk_b                   <= walk_b_nx;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Scoreboard bench for traffic_phase_sched against a phase/elapsed-count reference model.
module tb_traffic_phase_sched;

  localparam int MIN_GREEN = 4;
  localparam int MAX_GREEN = 10;
  localparam int YEL_CYC   = 2;
  localparam int CLR_CYC   = 1;
  localparam int WALK_CYC  = 3;

  logic clk, rst_n, sa, sb, ped_a, ped_b;
  logic ra, ya, ga, rb, yb, gb, walk_a, walk_b;
  logic [2:0] phase;

  traffic_phase_sched #(
    .MIN_GREEN (MIN_GREEN),
    .MAX_GREEN (MAX_GREEN),
    .YEL_CYC   (YEL_CYC),
    .CLR_CYC   (CLR_CYC),
    .WALK_CYC  (WALK_CYC)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sa     (sa),
    .sb     (sb),
    .ped_a  (ped_a),
    .ped_b  (ped_b),
    .ra     (ra),
    .ya     (ya),
    .ga     (ga),
    .rb     (rb),
    .yb     (yb),
    .gb     (gb),
    .walk_a (walk_a),
    .walk_b (walk_b),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Model: phase index 0..5 (road = idx/3, part = idx%3: clear/green/yellow),
  // cycles already spent in it, and pedestrian request / armed flags.
  int mp, mcnt;
  bit mlat_a, mlat_b, marm_a, marm_b;

  logic [10:0] sbq[$];

  localparam logic [10:0] RESET_VEC = 11'b100_100_00_000;

  function automatic logic [10:0] exp_vec();
    logic [2:0] la, lb;
    logic       wa, wb;
    logic [2:0] ph;
    la = (mp == 1) ? 3'b001 : (mp == 2) ? 3'b010 : 3'b100;
    lb = (mp == 4) ? 3'b001 : (mp == 5) ? 3'b010 : 3'b100;
    wa = (mp == 1) && marm_a && (mcnt < WALK_CYC);
    wb = (mp == 4) && marm_b && (mcnt < WALK_CYC);
    ph = 3'(mp);
    return {la, lb, wa, wb, ph};
  endfunction

  task automatic model_reset();
    mp = 0; mcnt = 0;
    mlat_a = 0; mlat_b = 0; marm_a = 0; marm_b = 0;
  endtask

  task automatic model_step(input bit a, input bit b, input bit pa, input bit pb);
    bit adem, bdem, own, opp, adv;
    int part, road, el, np;
    adem = a | mlat_a;
    bdem = b | mlat_b;
    road = mp / 3;
    part = mp % 3;
    own  = (road == 0) ? adem : bdem;
    opp  = (road == 0) ? bdem : adem;
    el   = mcnt + 1;
    case (part)
      0:       adv = (el >= CLR_CYC);
      1:       adv = (el >= MIN_GREEN) && opp && (!own || el >= MAX_GREEN);
      default: adv = (el >= YEL_CYC);
    endcase
    np = adv ? (mp + 1) % 6 : mp;
    if (adv && np == 1) begin
      marm_a = mlat_a; mlat_a = pa;
    end else begin
      mlat_a = mlat_a | pa;
      if (np != 1) marm_a = 0;
    end
    if (adv && np == 4) begin
      marm_b = mlat_b; mlat_b = pb;
    end else begin
      mlat_b = mlat_b | pb;
      if (np != 4) marm_b = 0;
    end
    mcnt = adv ? 0 : mcnt + 1;
    mp   = np;
  endtask

  // Inputs are applied 1ns after a rising edge; expected value of the next edge is queued.
  task automatic step(input bit a, input bit b, input bit pa, input bit pb);
    sa = a; sb = b; ped_a = pa; ped_b = pb;
    model_step(a, b, pa, pb);
    @(posedge clk);
    sbq.push_back(exp_vec());
    #1;
  endtask

  task automatic hold_reset(input int n);
    rst_n = 1'b0;
    sa = 0; sb = 0; ped_a = 0; ped_b = 0;
    model_reset();
    sbq.delete();
    sbq.push_back(RESET_VEC);
    repeat (n) begin
      @(posedge clk);
      sbq.push_back(RESET_VEC);
    end
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compares every presented output cycle against the queue head.
  always @(negedge clk) begin
    logic [10:0] act, e;
    cyc++;
    act = {ra, ya, ga, rb, yb, gb, walk_a, walk_b, phase};
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d got {r,y,g a|r,y,g b|wa,wb|ph}=%b expected %b", cyc, act, e);
      end
    end
    checks++;
    if (((ga | ya) & (gb | yb)) || ({1'b0, ra} + ya + ga != 2'd1) || ({1'b0, rb} + yb + gb != 2'd1)) begin
      errors++;
      $display("FAIL safety cyc=%0d got lamps A=%b%b%b B=%b%b%b expected one lamp per road, no dual go",
               cyc, ra, ya, ga, rb, yb, gb);
    end
  end

  initial begin
    bit a, b;
    rst_n = 1'b0; sa = 0; sb = 0; ped_a = 0; ped_b = 0;
    model_reset();
    @(posedge clk); #1;

    // Idle: green A rests, no walk
    hold_reset(2);
    repeat (52) step(0, 0, 0, 0);

    // B demand arrives at GRN_A tmr=1
    hold_reset(2);
    for (int i = 0; i < 20 && !(mp == 1 && mcnt == 1); i++) step(0, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0);

    // Both roads demanding: alternating max greens
    hold_reset(2);
    repeat (60) step(1, 1, 0, 0);

    // Ped A pulse during GRN_B with sb dropped
    hold_reset(2);
    for (int i = 0; i < 40 && mp != 4; i++) step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    repeat (30) step(0, 0, 0, 0);

    // Asynchronous reset in the middle of YEL_B
    hold_reset(2);
    for (int i = 0; i < 60 && mp != 5; i++) step(1, 1, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ra, ya, ga, rb, yb, gb, walk_a, walk_b, phase} !== RESET_VEC) begin
      errors++;
      $display("FAIL async_reset got %b expected %b",
               {ra, ya, ga, rb, yb, gb, walk_a, walk_b, phase}, RESET_VEC);
    end
    hold_reset(2);
    repeat (30) step(1, 1, 0, 0);

    // Randomised demand with slowly toggling sensors and sparse ped pulses
    hold_reset(2);
    a = 0; b = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(7) == 0) a = ~a;
      if ($urandom_range(7) == 0) b = ~b;
      step(a, b, $urandom_range(19) == 0, $urandom_range(19) == 0);
    end

    @(negedge clk); #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
